// File: rtl/uart_rx_deframer.sv
// 8N1 UART receive deframer running on the board clock.
// The 16x rxClk is sampled as data and edge-detected into a one-clk tick.
`timescale 1ns/1ps

module uart_rx_deframer #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 rxClk,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dataOut,
    output logic                 dataValid,
    input  logic                 dataReady,
    output logic                 frameError,
    output logic                 overrun,
    input  logic                 clearOverrun,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] TC_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TC_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BC_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    logic [SYNC_STAGES-1:0] r_rx_sync;
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic                   r_clk_prev;

    state_t                 r_state;
    logic [TW-1:0]          r_tc;
    logic [BW-1:0]          r_bc;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_busy;
    logic                   r_frame_err;

    logic [DATA_BITS-1:0]   r_data;
    logic                   r_valid;
    logic                   r_overrun;

    logic w_rxs;
    logic w_tick;
    logic w_tc_mid;
    logic w_tc_last;
    logic w_bc_last;
    logic w_good;
    logic w_accept;
    logic w_load;
    logic w_drop;

    // Synchronisers preset high so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_rx_sync  <= '1;
            r_clk_sync <= '1;
            r_clk_prev <= 1'b1;
        end else begin
            r_rx_sync  <= {r_rx_sync[SYNC_STAGES-2:0], rx};
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], rxClk};
            r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
        end
    end

    assign w_rxs     = r_rx_sync[SYNC_STAGES-1];
    assign w_tick    = r_clk_sync[SYNC_STAGES-1] & ~r_clk_prev;
    assign w_tc_mid  = (r_tc == TC_MID);
    assign w_tc_last = (r_tc == TC_LAST);
    assign w_bc_last = (r_bc == BC_LAST);

    assign w_good   = w_tick && (r_state == S_STOP) && w_tc_last && w_rxs;
    assign w_accept = r_valid && dataReady;
    assign w_load   = w_good && (!r_valid || dataReady);
    assign w_drop   = w_good && r_valid && !dataReady;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state     <= S_IDLE;
            r_tc        <= '0;
            r_bc        <= '0;
            r_shift     <= '0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (w_tick) begin
                unique case (r_state)
                    S_IDLE: begin
                        if (!w_rxs) begin
                            r_state <= S_START;
                            r_tc    <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_START: begin
                        if (w_tc_mid) begin
                            r_tc <= '0;
                            if (!w_rxs) begin
                                r_state <= S_DATA;
                                r_bc    <= '0;
                            end else begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_tc <= r_tc + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (w_tc_last) begin
                            // LSB arrives first, so bytes enter from the top.
                            r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
                            r_tc    <= '0;
                            if (w_bc_last) begin
                                r_bc    <= '0;
                                r_state <= S_STOP;
                            end else begin
                                r_bc <= r_bc + 1'b1;
                            end
                        end else begin
                            r_tc <= r_tc + 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (w_tc_last) begin
                            r_tc <= '0;
                            if (w_rxs) begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state     <= S_WAIT_HIGH;
                                r_frame_err <= 1'b1;
                            end
                        end else begin
                            r_tc <= r_tc + 1'b1;
                        end
                    end
                    S_WAIT_HIGH: begin
                        if (w_rxs) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Holding register: a load in the accepting cycle keeps dataValid high.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clearOverrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign dataOut    = r_data;
    assign dataValid  = r_valid;
    assign frameError = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed and random 8N1 frames against a byte-queue scoreboard.
`timescale 1ns/1ps

module tb_uart_rx_deframer;

    localparam time CLK_HALF = 5;
    localparam time RXC_HALF = 40;
    localparam time BIT      = 1280;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       rxClk = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] dataOut;
    logic       dataValid;
    logic       dataReady = 1'b0;
    logic       frameError;
    logic       overrun;
    logic       clearOverrun = 1'b0;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int fe_cnt = 0;
    logic [7:0] acc[$];
    logic [7:0] exp_q[$];

    uart_rx_deframer dut (
        .clk(clk),
        .rstN(rstN),
        .rxClk(rxClk),
        .rx(rx),
        .dataOut(dataOut),
        .dataValid(dataValid),
        .dataReady(dataReady),
        .frameError(frameError),
        .overrun(overrun),
        .clearOverrun(clearOverrun),
        .busy(busy)
    );

    always #CLK_HALF clk = ~clk;

    initial begin
        #7;
        forever #RXC_HALF rxClk = ~rxClk;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Consumer-side view: bytes actually handed over, and error pulses.
    always @(posedge clk) begin
        if (rstN) begin
            if (dataValid && dataReady) acc.push_back(dataOut);
            if (frameError) fe_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        #BIT;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #BIT;
        end
        rx = stop;
        #BIT;
    endtask

    task automatic clear_scoreboard();
        acc.delete();
        fe_cnt = 0;
    endtask

    initial begin
        logic [7:0] b;
        int found;

        // reset
        #22;
        chk("rst_valid", {31'd0, dataValid}, 32'd0);
        chk("rst_data", {24'd0, dataOut}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ferr", {31'd0, frameError}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        #81;
        rstN = 1'b1;
        #(BIT);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        // nominal 0xA5
        @(negedge clk);
        dataReady = 1'b1;
        clear_scoreboard();
        fork
            send_frame(8'hA5, 1'b1);
            begin
                #(BIT * 3);
                chk("nom_busy_mid", {31'd0, busy}, 32'd1);
            end
        join
        #(BIT / 2);
        chk("nom_count", acc.size(), 32'd1);
        if (acc.size() > 0) chk("nom_byte", {24'd0, acc[0]}, 32'hA5);
        chk("nom_ferr", fe_cnt, 32'd0);
        chk("nom_ovr", {31'd0, overrun}, 32'd0);
        chk("nom_busy_end", {31'd0, busy}, 32'd0);
        chk("nom_valid_end", {31'd0, dataValid}, 32'd0);

        // start glitch then 0x3C
        clear_scoreboard();
        rx = 1'b0;
        #400;
        rx = 1'b1;
        #(BIT * 2);
        chk("glitch_busy", {31'd0, busy}, 32'd0);
        chk("glitch_count", acc.size(), 32'd0);
        chk("glitch_ferr", fe_cnt, 32'd0);
        send_frame(8'h3C, 1'b1);
        #(BIT / 2);
        chk("glitch_next_count", acc.size(), 32'd1);
        if (acc.size() > 0) chk("glitch_next_byte", {24'd0, acc[0]}, 32'h3C);

        // frame error, break, then 0x0F
        clear_scoreboard();
        send_frame(8'h55, 1'b0);
        #(BIT * 3);
        chk("ferr_count", fe_cnt, 32'd1);
        chk("ferr_nodata", acc.size(), 32'd0);
        chk("ferr_busy_low", {31'd0, busy}, 32'd1);
        chk("ferr_valid", {31'd0, dataValid}, 32'd0);
        rx = 1'b1;
        #(BIT);
        chk("ferr_busy_rel", {31'd0, busy}, 32'd0);
        chk("ferr_count_after", fe_cnt, 32'd1);
        send_frame(8'h0F, 1'b1);
        #(BIT / 2);
        chk("ferr_next_count", acc.size(), 32'd1);
        if (acc.size() > 0) chk("ferr_next_byte", {24'd0, acc[0]}, 32'h0F);

        // back-pressure and overrun
        @(negedge clk);
        dataReady = 1'b0;
        clear_scoreboard();
        send_frame(8'h11, 1'b1);
        #(BIT / 2);
        chk("bp_valid1", {31'd0, dataValid}, 32'd1);
        chk("bp_ovr1", {31'd0, overrun}, 32'd0);
        send_frame(8'h22, 1'b1);
        #(BIT / 2);
        chk("bp_data", {24'd0, dataOut}, 32'h11);
        chk("bp_valid2", {31'd0, dataValid}, 32'd1);
        chk("bp_ovr2", {31'd0, overrun}, 32'd1);
        @(negedge clk);
        dataReady = 1'b1;
        @(negedge clk);
        dataReady = 1'b0;
        chk("bp_drain_valid", {31'd0, dataValid}, 32'd0);
        chk("bp_drain_count", acc.size(), 32'd1);
        if (acc.size() > 0) chk("bp_drain_byte", {24'd0, acc[0]}, 32'h11);
        chk("bp_ovr_sticky", {31'd0, overrun}, 32'd1);
        clearOverrun = 1'b1;
        @(negedge clk);
        clearOverrun = 1'b0;
        chk("bp_ovr_clr", {31'd0, overrun}, 32'd0);

        // accept and load in the same clk
        clear_scoreboard();
        send_frame(8'h66, 1'b1);
        #(BIT / 2);
        chk("sim_hold_valid", {31'd0, dataValid}, 32'd1);
        chk("sim_hold_data", {24'd0, dataOut}, 32'h66);
        found = 0;
        fork
            send_frame(8'h77, 1'b1);
            begin
                for (int i = 0; i < 2000; i++) begin
                    @(negedge clk);
                    if (dut.w_good) begin
                        found = 1;
                        break;
                    end
                end
                dataReady = 1'b1;
                @(negedge clk);
                dataReady = 1'b0;
            end
        join
        chk("sim_found", found, 32'd1);
        #(BIT / 2);
        chk("sim_count", acc.size(), 32'd1);
        if (acc.size() > 0) chk("sim_consumed", {24'd0, acc[0]}, 32'h66);
        chk("sim_data", {24'd0, dataOut}, 32'h77);
        chk("sim_valid", {31'd0, dataValid}, 32'd1);
        chk("sim_ovr", {31'd0, overrun}, 32'd0);

        // async reset mid-frame
        clear_scoreboard();
        fork
            send_frame(8'hFF, 1'b1);
            begin
                #(BIT * 5 + BIT / 2 + 3);
                chk("arst_busy_pre", {31'd0, busy}, 32'd1);
                rstN = 1'b0;
                #1;
                chk("arst_valid", {31'd0, dataValid}, 32'd0);
                chk("arst_data", {24'd0, dataOut}, 32'd0);
                chk("arst_busy", {31'd0, busy}, 32'd0);
                chk("arst_ovr", {31'd0, overrun}, 32'd0);
            end
        join
        #(BIT / 2 + 4);
        rstN = 1'b1;
        #(BIT);
        chk("arst_idle", {31'd0, busy}, 32'd0);
        @(negedge clk);
        dataReady = 1'b1;
        send_frame(8'h81, 1'b1);
        #(BIT / 2);
        chk("arst_count", acc.size(), 32'd1);
        if (acc.size() > 0) chk("arst_byte", {24'd0, acc[0]}, 32'h81);
        chk("arst_ferr", fe_cnt, 32'd0);

        // random bytes with random idle gaps
        clear_scoreboard();
        exp_q.delete();
        for (int n = 0; n < 6; n++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, 1'b1);
            #($urandom_range(0, 600));
        end
        #(BIT);
        chk("rnd_count", acc.size(), exp_q.size());
        for (int n = 0; n < 6; n++) begin
            if (n < acc.size()) chk("rnd_byte", {24'd0, acc[n]},
                                    {24'd0, exp_q[n]});
        end
        chk("rnd_ferr", fe_cnt, 32'd0);
        chk("rnd_ovr", {31'd0, overrun}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Downstream consumer of the baud rate generator's 16x-oversampled rx clock.
- Recovers 8N1 serial frames from the asynchronous rx line and presents each byte on a valid/ready output port with a one-entry holding register.
- Runs entirely in the board clock domain: rxClk is sampled as data and edge-detected, never used as a clock.
- Feeds the matrix command/operand loader.

Parameters:
- DATA_BITS, 8: payload bits per frame, LSB first.
- OVERSAMPLE, 16: rxClk ticks per bit period. Must be even and >= 4.
- SYNC_STAGES, 2: flip-flop stages on the rx and rxClk inputs.

Ports:
- clk  input  1  board clock.
- rstN  input  1  asynchronous active-low reset.
- rxClk  input  1  16x oversample toggle from the baud generator, asynchronous to clk.
- rx  input  1  serial line, idle high.
- dataOut  output  DATA_BITS  received byte, stable while dataValid=1.
- dataValid  output  1  holding register full.
- dataReady  input  1  consumer accepts when dataValid && dataReady on a clk edge.
- frameError  output  1  one-clk pulse when the stop bit samples 0.
- overrun  output  1  sticky; set when a good frame completes while the holding register is full and not being emptied.
- clearOverrun  input  1  synchronous clear of overrun.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (rstN=0, async): all outputs 0, FSM=IDLE, counters 0, shift register 0, synchronisers preset to 1 so no false start.
- tick: one-clk pulse on each rising edge of the synchronised rxClk. A tick occurs OVERSAMPLE*2*N clk... no: with rxClk toggling every N clk, a tick occurs every 2N clk.
- rxS: rx after SYNC_STAGES flops.
- All FSM decisions happen only on tick cycles, except the output handshake, which is evaluated every clk.
- The FSM uses a tick counter tc (0..OVERSAMPLE-1) and a bit counter bc (0..DATA_BITS-1).
- IDLE: on a tick with rxS=0, go to START with tc=0.
- START: on each tick, tc++. At tc==OVERSAMPLE/2-1 (mid start bit):
  - rxS=0: go to DATA with tc=0, bc=0.
  - rxS=1: treat as a glitch and return to IDLE, with no output activity.
- DATA: on each tick, tc++. At tc==OVERSAMPLE-1:
  - Shift rxS in at the MSB side (LSB-first framing), set tc=0, bc++.
  - After DATA_BITS samples, go to STOP.
- STOP: at tc==OVERSAMPLE-1, sample rxS.
  - rxS=1, good frame: go to IDLE and perform the load rule below.
  - rxS=0: pulse frameError for 1 clk, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until a tick with rxS=1, then go to IDLE. This covers a break condition with no spurious frames.
- Load rule on a good frame:
  - If dataValid=0, or dataValid && dataReady in the same clk: dataOut <= byte, dataValid <= 1 on the next clk edge, overrun unchanged.
  - Otherwise: byte dropped, dataOut/dataValid unchanged, overrun <= 1.
- Handshake:
  - dataValid clears on a clk with dataValid && dataReady and no simultaneous load.
  - dataOut must not change while dataValid=1 unless a load occurs in the accepting cycle.
- overrun: clearOverrun=1 clears it. If a set and a clear occur in the same clk, set wins.
- Latency: from the stop-bit sample tick, dataValid rises 1 clk later.
- busy=1 in START, DATA, STOP and WAIT_HIGH.
- Reset mid-frame: immediate return to IDLE. The partial byte is lost, and dataValid and overrun clear.
- No timing dependency on CLOCK_RATE: the block tracks whatever tick rate rxClk delivers.

Test Plan:
- Nominal byte, rxClk toggled every 4 clk (tick every 8 clk, bit = 128 clk), send 0xA5 8N1 with dataReady=1 -> one dataValid cycle with dataOut=0xA5, frameError=0, overrun=0, busy returns to 0.
- Start glitch: rx low for 40 clk (5 ticks), then high -> FSM returns to IDLE, no dataValid, no frameError; a following 0x3C frame is received correctly.
- Frame error: send 0x55 with stop bit 0, then hold rx low for 3 bit times -> exactly one frameError pulse, no dataValid, busy stays 1 until rx goes high; the next frame 0x0F is received.
- Back-pressure/overrun: dataReady=0, send 0x11 then 0x22 -> dataOut stays 0x11, dataValid=1, overrun=1 after the second stop bit. Then dataReady=1 for 1 clk -> dataValid=0. Then clearOverrun -> overrun=0.
- Simultaneous accept and load: dataReady pulsed exactly in the clk the second frame (0x77) completes, with 0x66 held -> 0x66 consumed, dataOut=0x77, dataValid stays 1, overrun=0.
- Async reset mid-frame: assert rstN=0 during DATA bit 4 of 0xFF -> outputs 0 immediately; after release, a fresh 0x81 frame is received correctly with no residue.
